// File: rtl/cpu_controller.sv
// Instruction register, decoder and control FSM for the Simple RISC Machine datapath.
// All outputs are Moore: decoded from the state register and IR only.
//
// state     | meaning
// WAIT      | idle, w=1, IR loadable, s starts execution
// DECODE    | classify IR and branch
// GET_A     | read Rn into A
// GET_B     | read Rm into B
// EXEC      | ALU operation, load C (or status for CMP)
// WRITE_REG | write C back to Rd
// WRITE_IMM | write sximm8 to Rn
module cpu_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8
);

  localparam logic [2:0] WAIT      = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] GET_A     = 3'd2;
  localparam logic [2:0] GET_B     = 3'd3;
  localparam logic [2:0] EXEC      = 3'd4;
  localparam logic [2:0] WRITE_REG = 3'd5;
  localparam logic [2:0] WRITE_IMM = 3'd6;

  logic [2:0]  state, state_nxt;
  logic [15:0] ir;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op;
  logic       is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign is_cmp     = is_alu && (op == 2'b01);

  assign shift  = ir[4:3];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WAIT;
      ir    <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (state == WAIT && load)
        ir <= in;
    end
  end

  // Decode sees the IR already updated when load and s arrive together.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT:      if (s) state_nxt = DECODE;
      DECODE: begin
        if (is_mov_imm)                state_nxt = WRITE_IMM;
        else if (is_mov_reg || is_mvn) state_nxt = GET_B;
        else if (is_alu)               state_nxt = GET_A;
        else                           state_nxt = WAIT;
      end
      GET_A:     state_nxt = GET_B;
      GET_B:     state_nxt = EXEC;
      EXEC:      state_nxt = is_cmp ? WAIT : WRITE_REG;
      WRITE_REG: state_nxt = WAIT;
      WRITE_IMM: state_nxt = WAIT;
      default:   state_nxt = WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 1'b0;
    ALUop    = 2'b00;
    case (state)
      WAIT:  w = 1'b1;
      GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      EXEC: begin
        asel  = is_mov_reg || is_mvn;
        ALUop = is_mov_reg ? 2'b00 : op;
        if (is_cmp) loads = 1'b1;
        else        loadc = 1'b1;
      end
      WRITE_REG: begin
        writenum = rd;
        write    = 1'b1;
      end
      WRITE_IMM: begin
        writenum = rn;
        vsel     = 1'b1;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: each task drives one instruction scenario
// and checks the decoded strobes cycle by cycle, sampling on the falling edge.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in;
  logic        load, s;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel, vsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk(clk), .rst_n(rst_n), .in(in), .load(load), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8)
  );

  // strobe vector {loada, loadb, loadc, loads, write, vsel, asel, bsel}
  function automatic logic [7:0] strobes();
    return {loada, loadb, loadc, loads, write, vsel, asel, bsel};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in = 16'h0000; load = 1'b0; s = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (w !== 1'b1) $display("FAIL reset_w: got %b want 1", w); else passed++;
    total++; if (strobes() !== 8'h00) $display("FAIL reset_strobes: got %h want 00", strobes()); else passed++;
    total++; if ({readnum, writenum} !== 6'd0) $display("FAIL reset_regnums: got %h want 00", {readnum, writenum}); else passed++;
    total++; if (sximm8 !== 16'h0000) $display("FAIL reset_sximm8: got %h want 0000", sximm8); else passed++;
  endtask

  task automatic test_mov_imm(input logic [15:0] instr, input logic [2:0] exp_rn, input logic [15:0] exp_imm);
    in = instr; load = 1'b1;
    tick();
    load = 1'b0; s = 1'b1;
    tick();   // DECODE
    s = 1'b0;
    total++; if (w !== 1'b0 || write !== 1'b0) $display("FAIL movi_decode: got w=%b write=%b want 0 0", w, write); else passed++;
    tick();   // WRITE_IMM
    total++; if (writenum !== exp_rn) $display("FAIL movi_writenum: got %0d want %0d", writenum, exp_rn); else passed++;
    total++; if (strobes() !== 8'b0000_1100) $display("FAIL movi_strobes: got %b want 00001100", strobes()); else passed++;
    total++; if (sximm8 !== exp_imm) $display("FAIL movi_sximm8: got %h want %h", sximm8, exp_imm); else passed++;
    tick();
    total++; if (w !== 1'b1) $display("FAIL movi_done_w: got %b want 1", w); else passed++;
  endtask

  task automatic test_add();
    in = 16'hA0A2; load = 1'b1; s = 1'b1;   // load and start on the same edge
    tick();   // DECODE
    load = 1'b0; s = 1'b0;
    tick();   // GET_A
    total++; if (readnum !== 3'd0 || strobes() !== 8'b1000_0000) $display("FAIL add_geta: got rn=%0d st=%b want 0 10000000", readnum, strobes()); else passed++;
    tick();   // GET_B
    total++; if (readnum !== 3'd2 || strobes() !== 8'b0100_0000) $display("FAIL add_getb: got rn=%0d st=%b want 2 01000000", readnum, strobes()); else passed++;
    tick();   // EXEC
    total++; if (ALUop !== 2'b00 || strobes() !== 8'b0010_0000) $display("FAIL add_exec: got op=%b st=%b want 00 00100000", ALUop, strobes()); else passed++;
    tick();   // WRITE_REG
    total++; if (writenum !== 3'd5 || strobes() !== 8'b0000_1000) $display("FAIL add_write: got wn=%0d st=%b want 5 00001000", writenum, strobes()); else passed++;
    total++; if (w !== 1'b0) $display("FAIL add_busy_w: got %b want 0", w); else passed++;
    tick();
    total++; if (w !== 1'b1) $display("FAIL add_done_w: got %b want 1", w); else passed++;
  endtask

  task automatic test_cmp();
    int n_loadc = 0, n_write = 0, n_loads = 0, busy = 0;
    in = 16'hA90B; load = 1'b1;
    tick();
    load = 1'b0; s = 1'b1;
    total++; if (shift !== 2'b01) $display("FAIL cmp_shift: got %b want 01", shift); else passed++;
    tick();
    s = 1'b0;
    for (int i = 0; i < 8 && w !== 1'b1; i++) begin
      busy++;
      if (loadc) n_loadc++;
      if (write) n_write++;
      if (loads) begin
        n_loads++;
        total++; if (ALUop !== 2'b01) $display("FAIL cmp_aluop: got %b want 01", ALUop); else passed++;
      end
      tick();
    end
    total++; if (n_loads !== 1) $display("FAIL cmp_loads: got %0d want 1", n_loads); else passed++;
    total++; if (n_loadc !== 0 || n_write !== 0) $display("FAIL cmp_no_wb: got loadc=%0d write=%0d want 0 0", n_loadc, n_write); else passed++;
    total++; if (busy !== 4) $display("FAIL cmp_latency: got %0d want 4", busy); else passed++;
  endtask

  task automatic test_mvn_ignore();
    in = 16'hB8E4; load = 1'b1;
    tick();
    load = 1'b0; s = 1'b1;
    tick();   // DECODE
    in = 16'hD105; load = 1'b1;               // must be ignored while busy
    tick();   // GET_B
    total++; if (readnum !== 3'd4 || strobes() !== 8'b0100_0000) $display("FAIL mvn_getb: got rn=%0d st=%b want 4 01000000", readnum, strobes()); else passed++;
    tick();   // EXEC
    total++; if (ALUop !== 2'b11 || strobes() !== 8'b0010_0010) $display("FAIL mvn_exec: got op=%b st=%b want 11 00100010", ALUop, strobes()); else passed++;
    total++; if (sximm8 !== 16'hFFE4) $display("FAIL mvn_ir_stable: got %h want ffe4", sximm8); else passed++;
    tick();   // WRITE_REG
    load = 1'b0; s = 1'b0;
    total++; if (writenum !== 3'd7 || write !== 1'b1) $display("FAIL mvn_write: got wn=%0d write=%b want 7 1", writenum, write); else passed++;
    tick();
    total++; if (w !== 1'b1 || sximm8 !== 16'hFFE4) $display("FAIL mvn_done: got w=%b imm=%h want 1 ffe4", w, sximm8); else passed++;
  endtask

  task automatic test_mov_reg();
    in = 16'hC0AB; load = 1'b1; s = 1'b1;     // MOV R5, R3, LSL#1
    tick();
    load = 1'b0; s = 1'b0;
    tick();   // GET_B
    total++; if (readnum !== 3'd3 || loadb !== 1'b1 || loada !== 1'b0) $display("FAIL movr_getb: got rn=%0d la=%b lb=%b want 3 0 1", readnum, loada, loadb); else passed++;
    tick();   // EXEC
    total++; if (ALUop !== 2'b00 || asel !== 1'b1 || loadc !== 1'b1 || shift !== 2'b01) $display("FAIL movr_exec: got op=%b asel=%b lc=%b sh=%b want 00 1 1 01", ALUop, asel, loadc, shift); else passed++;
    tick();   // WRITE_REG
    total++; if (writenum !== 3'd5 || vsel !== 1'b0 || write !== 1'b1) $display("FAIL movr_write: got wn=%0d vsel=%b write=%b want 5 0 1", writenum, vsel, write); else passed++;
    tick();
    total++; if (w !== 1'b1) $display("FAIL movr_done_w: got %b want 1", w); else passed++;
  endtask

  task automatic test_unsupported();
    in = 16'h0000; load = 1'b1; s = 1'b1;
    tick();   // DECODE
    load = 1'b0; s = 1'b0;
    total++; if (w !== 1'b0 || strobes() !== 8'h00) $display("FAIL unsup_decode: got w=%b st=%b want 0 00000000", w, strobes()); else passed++;
    tick();
    total++; if (w !== 1'b1 || strobes() !== 8'h00) $display("FAIL unsup_done: got w=%b st=%b want 1 00000000", w, strobes()); else passed++;
  endtask

  task automatic test_back_to_back();
    in = 16'hD203; load = 1'b1; s = 1'b1;     // MOV R2, #3 with s held
    tick();   // DECODE
    load = 1'b0;
    tick();   // WRITE_IMM
    total++; if (writenum !== 3'd2 || write !== 1'b1) $display("FAIL b2b_first_write: got wn=%0d write=%b want 2 1", writenum, write); else passed++;
    tick();   // WAIT
    total++; if (w !== 1'b1) $display("FAIL b2b_gap_w: got %b want 1", w); else passed++;
    tick();   // DECODE again
    s = 1'b0;
    total++; if (w !== 1'b0) $display("FAIL b2b_restart: got %b want 0", w); else passed++;
    tick();
    total++; if (write !== 1'b1 || sximm8 !== 16'h0003) $display("FAIL b2b_second_write: got write=%b imm=%h want 1 0003", write, sximm8); else passed++;
    tick();
    total++; if (w !== 1'b1) $display("FAIL b2b_done_w: got %b want 1", w); else passed++;
  endtask

  task automatic test_reset_mid_add();
    int n_write = 0;
    in = 16'hA0A2; load = 1'b1; s = 1'b1;
    tick();   // DECODE
    load = 1'b0; s = 1'b0;
    tick(); tick(); tick();   // GET_A, GET_B, EXEC
    total++; if (loadc !== 1'b1) $display("FAIL rst_mid_in_exec: got loadc=%b want 1", loadc); else passed++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (w !== 1'b1 || strobes() !== 8'h00) $display("FAIL rst_mid_state: got w=%b st=%b want 1 00000000", w, strobes()); else passed++;
    total++; if (sximm8 !== 16'h0000 || shift !== 2'b00) $display("FAIL rst_mid_ir: got imm=%h sh=%b want 0000 00", sximm8, shift); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (write) n_write++;
      tick();
    end
    total++; if (n_write !== 0) $display("FAIL rst_mid_no_write: got %0d want 0", n_write); else passed++;
  endtask

  initial begin
    test_reset();
    test_mov_imm(16'hD105, 3'd1, 16'h0005);
    test_mov_imm(16'hD1FE, 3'd1, 16'hFFFE);
    test_add();
    test_cmp();
    test_mvn_ignore();
    test_mov_reg();
    test_unsupported();
    test_back_to_back();
    test_reset_mid_add();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
